// File: rtl/ula_seq_if.sv
// Request/response bundle for the sequential ULA: operation request with
// valid/ready, result words with valid/ready, status flags and error.
interface ula_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             flag_z;
    logic             flag_n;
    logic             flag_c;
    logic             flag_v;
    logic             err;

    // Requester / result consumer side
    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, result_hi,
               flag_z, flag_n, flag_c, flag_v, err
    );

    // ULA side
    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, result_hi,
               flag_z, flag_n, flag_c, flag_v, err
    );
endinterface

// File: rtl/ula_seq.sv
// Registered ULA with valid/ready handshakes, status flags, XOR, one-bit-per-
// cycle shifts and a shift-add multiplier. One operation in flight at a time.
module ula_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic      clk,
    input  logic      rst,
    ula_seq_if.slave  bus
);
    localparam int CW  = $clog2(WIDTH + 1);
    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_NOT = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] hi_q;
    logic             z_q, n_q, c_q, v_q, err_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [CW-1:0]    cnt_q;

    // Values loaded on the accept edge
    logic [WIDTH-1:0] acc_res;
    logic             acc_c, acc_v, acc_err, acc_multi;
    logic [CW-1:0]    acc_cnt;
    logic [WIDTH:0]   sum_ext, dif_ext;
    logic [SHW-1:0]   shamt;

    // Values produced by one BUSY iteration
    logic [WIDTH-1:0] st_res, st_hi;
    logic             st_c, st_v;
    logic [WIDTH:0]   madd;

    // Single-cycle results and multi-cycle setup from the live request
    always_comb begin
        sum_ext   = {1'b0, bus.a} + {1'b0, bus.b};
        dif_ext   = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
        shamt     = bus.b[SHW-1:0];
        acc_res   = '0;
        acc_c     = 1'b0;
        acc_v     = 1'b0;
        acc_err   = 1'b0;
        acc_multi = 1'b0;
        acc_cnt   = '0;
        case (bus.op)
            OP_ADD: begin
                acc_res = sum_ext[WIDTH-1:0];
                acc_c   = sum_ext[WIDTH];
                acc_v   = (bus.a[MSB] == bus.b[MSB]) && (sum_ext[MSB] != bus.a[MSB]);
            end
            OP_SUB: begin
                acc_res = dif_ext[WIDTH-1:0];
                acc_c   = dif_ext[WIDTH];
                acc_v   = (bus.a[MSB] != bus.b[MSB]) && (dif_ext[MSB] != bus.a[MSB]);
            end
            OP_AND: acc_res = bus.a & bus.b;
            OP_OR:  acc_res = bus.a | bus.b;
            OP_NOT: acc_res = ~bus.a;
            OP_XOR: acc_res = bus.a ^ bus.b;
            OP_SHL, OP_SHR: begin
                acc_res   = bus.a;
                acc_multi = (shamt != '0);
                acc_cnt   = CW'(shamt);
            end
            OP_MUL: begin
                // Multiplier rides in the low result word and is consumed
                // from bit 0 as the product shifts in from the top.
                acc_res   = bus.b;
                acc_multi = 1'b1;
                acc_cnt   = CW'(WIDTH);
            end
            default: acc_err = 1'b1;
        endcase
    end

    // One shift step or one shift-add multiply step on the held operands
    always_comb begin
        st_res = res_q;
        st_hi  = '0;
        st_c   = 1'b0;
        st_v   = 1'b0;
        madd   = {1'b0, hi_q} + (res_q[0] ? {1'b0, a_q} : '0);
        case (op_q)
            OP_SHL: begin
                st_res = res_q << 1;
                st_c   = res_q[MSB];
            end
            OP_SHR: begin
                st_res = res_q >> 1;
                st_c   = res_q[0];
            end
            OP_MUL: begin
                st_hi  = madd[WIDTH:1];
                st_res = {madd[0], res_q[WIDTH-1:1]};
                st_c   = (madd[WIDTH:1] != '0);
                st_v   = (madd[WIDTH:1] != '0);
            end
            default: ;
        endcase
    end

    // Control FSM with registered handshake outputs, result and flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            hi_q        <= '0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            err_q       <= 1'b0;
            op_q        <= '0;
            a_q         <= '0;
            cnt_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_q       <= bus.op;
                        a_q        <= bus.a;
                        cnt_q      <= acc_cnt;
                        res_q      <= acc_res;
                        hi_q       <= '0;
                        z_q        <= (acc_res == '0) && !acc_err;
                        n_q        <= acc_res[MSB];
                        c_q        <= acc_c;
                        v_q        <= acc_v;
                        err_q      <= acc_err;
                        in_ready_q <= 1'b0;
                        if (acc_multi) begin
                            state <= BUSY;
                        end else begin
                            state       <= DONE;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    res_q <= st_res;
                    hi_q  <= st_hi;
                    z_q   <= (st_res == '0) && (st_hi == '0);
                    n_q   <= st_res[MSB];
                    c_q   <= st_c;
                    v_q   <= st_v;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = res_q;
    assign bus.result_hi = hi_q;
    assign bus.flag_z    = z_q;
    assign bus.flag_n    = n_q;
    assign bus.flag_c    = c_q;
    assign bus.flag_v    = v_q;
    assign bus.err       = err_q;
endmodule

// File: doc/ula_seq.md
Name: ula_seq

Overview:
- Parametrised, registered successor of the 8-bit combinational ULA; default WIDTH=8.
- Adds:
  - valid/ready handshakes on input and output;
  - status flags;
  - XOR;
  - multi-cycle barrel-free shifts;
  - multi-cycle shift-add multiply.
- Sits between the operand/register datapath and the writeback stage; one operation in flight at a time.

Parameters:
- WIDTH, 8, operand/result width; must be >= 2.
- SHW, $clog2(WIDTH), width of the shift-amount field taken from b[SHW-1:0].

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  block can accept a request (high only in IDLE).
- op  input  4  opcode, see Behaviour.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer takes result.
- result  output  WIDTH  low result word.
- result_hi  output  WIDTH  high product word (MUL only, else 0).
- flag_z  output  1  result == 0 (and result_hi == 0 for MUL).
- flag_n  output  1  result[WIDTH-1].
- flag_c  output  1  carry / no-borrow / last bit shifted out / MUL high-nonzero.
- flag_v  output  1  signed overflow (ADD/SUB); MUL high-nonzero; else 0.
- err  output  1  illegal opcode.

Behaviour:
- Reset (rst=1 at edge, overrides everything, including mid-operation):
  - state=IDLE;
  - in_ready=1, out_valid=0;
  - result, result_hi, all flags and err = 0;
  - any in-flight operation is discarded.
- States: IDLE, BUSY, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
- Accept: edge with in_valid & in_ready latches op, a, b.
  - Single-cycle op: go to DONE with outputs computed.
  - SHL/SHR with n=b[SHW-1:0] > 0: go to BUSY with counter=n.
  - MUL: go to BUSY with counter=WIDTH.
- Opcodes:
  - 0 ADD: a+b; c = carry out.
  - 1 SUB: a+~b+1; c = carry out (1 = no borrow).
  - 2 AND.
  - 3 OR.
  - 4 NOT a.
  - 5 XOR.
  - 6 SHL: logical shift left by n.
  - 7 SHR: logical shift right by n.
  - 8 MUL: unsigned; {result_hi,result} = a*b.
  - 9-15 illegal: result=0, err=1, other flags 0, latency 1.
- Overflow V:
  - ADD: V = (a[msb]==b[msb]) & (sum[msb]!=a[msb]).
  - SUB: V = (a[msb]!=b[msb]) & (diff[msb]!=a[msb]).
  - Logic ops: c=v=0.
- Shifts:
  - One bit per BUSY cycle; c = last bit shifted out.
  - n=0: result=a, c=0, latency 1.
  - Bits of b above SHW are ignored.
- MUL: one shift-add iteration per BUSY cycle, WIDTH iterations; c=v=(result_hi!=0).
- Latency (accept edge to first edge where out_valid is sampled high):
  - Single-cycle ops and illegal opcodes: 1.
  - Shift: n+1.
  - MUL: WIDTH+1.
- BUSY: counter decrements each cycle; entry to DONE on the edge where the final iteration completes. Outputs are not valid in BUSY (out_valid=0); result may change in BUSY.
- DONE: result, flags and err are held stable until out_ready=1; that edge goes to IDLE.
  - in_ready first rises the cycle after the handshake; no back-to-back acceptance.
  - Max throughput is one op per 2 cycles for single-cycle ops.
- in_valid, op, a and b are ignored while not in IDLE. The latched copies are used, so input changes during BUSY/DONE have no effect.
- err clears on the next accepted legal op. Outputs otherwise keep their last values in IDLE.

Test Plan:
- Reset mid-MUL: accept MUL a=8'hFF b=8'hFF, assert rst on 3rd BUSY cycle -> next cycle state IDLE, out_valid=0, result=0, in_ready=1.
- ADD a=8'h7F b=8'h01 -> 1 cycle later out_valid=1, result=8'h80, n=1, v=1, c=0, z=0.
- ADD 8'hFF+8'h01 -> result=8'h00, z=1, c=1, v=0.
- SUB 8'h05-8'h07 -> result=8'hFE, c=0, n=1.
- SUB 8'h80-8'h01 -> result=8'h7F, v=1, c=1.
- MUL a=8'h10 b=8'h20, out_ready held low 5 extra cycles -> out_valid at latency 9; result_hi=8'h02, result=8'h00, c=v=1, z=0; outputs stable until out_ready, then in_ready=1 next cycle.
- Shifts:
  - SHL a=8'h81 b=8'h03 -> latency 4, result=8'h08, c=0.
  - SHR a=8'h81 b=8'h01 -> result=8'h40, c=1.
  - SHL b=8'h08 (n=0) -> latency 1, result=8'h81.
- Illegal op=4'hC -> latency 1, err=1, result=0. A following XOR a=8'hF0 b=8'h3C -> result=8'hCC, err=0. Toggling a/b/op during DONE leaves outputs unchanged.
